decoder_2x4_strobe: RTL

DECODER_2X4_STROBE -- requirements
Module: decoder_2x4_strobe

---
 rtl/decoder_2x4_strobe.sv | 117 +++++++++++
 1 files changed

// File: rtl/decoder_2x4_strobe.sv
`default_nettype none
// ============================================================================
// Module      : decoder_2x4_strobe
// Description : 2-to-4 decoder that turns each accepted code into a timed
//               strobe on one of four output lines, followed by a guard gap.
// Revision    : 1.0  initial release
// ============================================================================
module decoder_2x4_strobe #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic a0,
    input  logic a1,
    input  logic in_valid,
    output logic in_ready,
    output logic d0,
    output logic d1,
    output logic d2,
    output logic d3,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Counters hold "cycles remaining minus one", so zero marks the last cycle.
    localparam logic [7:0] c_pulse_load = 8'(PULSE_LEN - 1);
    localparam logic [7:0] c_gap_load   = (GAP_LEN == 0) ? 8'd0 : 8'(GAP_LEN - 1);
    localparam logic       c_short      = (PULSE_LEN == 1);
    localparam logic       c_no_gap     = (GAP_LEN == 0);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_code;
    logic [3:0]  r_d;
    logic        r_done;
    logic [1:0]  w_code;

    assign w_code = {a1, a0};

    function automatic logic [3:0] one_hot(input logic [1:0] code);
        logic [3:0] v;
        v = 4'b0000;
        v[code] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_code  <= 2'd0;
            r_d     <= 4'b0000;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_d <= 4'b0000;
                    if (in_valid) begin
                        r_code  <= w_code;
                        r_d     <= one_hot(w_code);
                        r_cnt   <= c_pulse_load;
                        r_done  <= c_short;
                        r_state <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == 8'd0) begin
                        r_d <= 4'b0000;
                        if (c_no_gap) begin
                            r_cnt   <= 8'd0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= c_gap_load;
                            r_state <= S_GAP;
                        end
                    end else begin
                        // Line is re-derived from the captured code, never from the live inputs.
                        r_d    <= one_hot(r_code);
                        r_cnt  <= r_cnt - 8'd1;
                        r_done <= (r_cnt == 8'd1);
                    end
                end
                S_GAP: begin
                    r_d <= 4'b0000;
                    if (r_cnt == 8'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_d     <= 4'b0000;
                    r_cnt   <= 8'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign d0       = r_d[0];
    assign d1       = r_d[1];
    assign d2       = r_d[2];
    assign d3       = r_d[3];

endmodule
`default_nettype wire
